// File: rtl/seq_restoring_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

  // Smallest n with 2**n >= v; sizes the iteration counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_restoring_div_sub.sv
// Ripple-carry subtractor: o_diff = i_a + ~i_b + 1, o_cout=1 means no borrow.
module SUB #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_cout
);

  logic [W:0]   w_c;
  logic [W-1:0] w_bn;

  assign w_bn   = ~i_b;
  assign w_c[0] = 1'b1;

  for (genvar g = 0; g < W; g++) begin : g_fa
    assign o_diff[g] = i_a[g] ^ w_bn[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & w_bn[g]) | (w_c[g] & (i_a[g] ^ w_bn[g]));
  end

  assign o_cout = w_c[W];

endmodule

// File: rtl/seq_restoring_div.sv
// Iterative restoring divider, one quotient bit per clock, signed or unsigned,
// with valid/ready handshakes on operand and result sides.
module seq_restoring_div
  import div_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         is_signed,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = clog2(W + 1);

  div_state_e    r_state, w_state_nxt;
  logic [W-1:0]  r_q, r_rem, r_b, r_quot, r_remo;
  logic [CW-1:0] r_cnt;
  logic          r_neg_q, r_neg_r, r_dbz_pend, r_dbz;

  logic          w_accept, w_a_neg, w_b_neg, w_b_zero, w_ovf, w_last, w_cout;
  logic [W-1:0]  w_a_mag, w_b_mag, w_min;
  logic [W:0]    w_rem_sh, w_trial;

  assign w_min    = {1'b1, {(W-1){1'b0}}};
  assign w_a_neg  = is_signed & dividend[W-1];
  assign w_b_neg  = is_signed & divisor[W-1];
  assign w_a_mag  = w_a_neg ? (~dividend + 1'b1) : dividend;
  assign w_b_mag  = w_b_neg ? (~divisor + 1'b1) : divisor;
  assign w_b_zero = (divisor == '0);
  assign w_ovf    = is_signed & (dividend == w_min) & (divisor == '1);
  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_cnt == CW'(W - 1));

  assign w_rem_sh = {r_rem, r_q[W-1]};

  SUB #(.W(W + 1)) u_sub (
    .i_a    (w_rem_sh),
    .i_b    ({1'b0, r_b}),
    .o_diff (w_trial),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Special cases skip CALC but still pass through FIX, giving a one-edge result latency.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = (w_b_zero || w_ovf) ? FIX : CALC;
      end
      CALC: if (w_last) w_state_nxt = FIX;
      FIX:  w_state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= '0;
      r_rem      <= '0;
      r_b        <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_dbz      <= 1'b0;
      r_quot     <= '0;
      r_remo     <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          r_cnt <= '0;
          r_b   <= w_b_mag;
          // Special results are preloaded as final values with negation disabled.
          if (w_b_zero) begin
            r_q        <= '1;
            r_rem      <= dividend;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dbz_pend <= 1'b1;
          end else if (w_ovf) begin
            r_q        <= w_min;
            r_rem      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dbz_pend <= 1'b0;
          end else begin
            r_q        <= w_a_mag;
            r_rem      <= '0;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_dbz_pend <= 1'b0;
          end
        end
        CALC: begin
          r_rem <= w_cout ? w_trial[W-1:0] : w_rem_sh[W-1:0];
          r_q   <= {r_q[W-2:0], w_cout};
          r_cnt <= r_cnt + 1'b1;
        end
        FIX: begin
          r_quot <= r_neg_q ? (~r_q + 1'b1) : r_q;
          r_remo <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
          r_dbz  <= r_dbz_pend;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_div.sv
// Self-checking bench for seq_restoring_div (W=8): directed table, corner sequences, random vs model.
module tb_seq_restoring_div;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient, remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_restoring_div #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sgn;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic with the divide-by-zero and overflow rules.
  task automatic model(input logic s, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic z);
    int sa, sb;
    z = 1'b0;
    if (b == 8'h00) begin
      q = 8'hFF; r = a; z = 1'b1;
    end else if (s && a == 8'h80 && b == 8'hFF) begin
      q = 8'h80; r = 8'h00;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q = 8'(sa / sb);
      r = 8'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Drives one divide; lat = edges from accept to out_valid; rdy_bad counts in_ready=1 while busy.
  task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input int pre_stall, input int post_stall,
                        output logic [7:0] q, output logic [7:0] r, output logic z,
                        output int lat, output int rdy_bad, output bit ok);
    int n;
    ok = 1'b1;
    rdy_bad = 0;
    repeat (pre_stall) @(negedge clk);
    @(negedge clk);
    is_signed = s; dividend = a; divisor = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); n++;
    end
    if (!in_ready) ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    is_signed = $urandom_range(0, 1); dividend = 8'($urandom); divisor = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_bad++;
      @(negedge clk); lat++;
    end
    if (!out_valid) ok = 1'b0;
    repeat (post_stall) begin
      if (in_ready) rdy_bad++;
      @(negedge clk);
    end
    q = quotient; r = remainder; z = div_by_zero;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t       tbl[$];
    logic [7:0] q, r, eq, er, sq, sr;
    logic       z, ez, sz;
    int         lat, rb, errs_rnd;
    bit         ok;

    tbl.push_back('{1'b0, 8'd100, 8'd7,  8'h0E, 8'h02, 1'b0, 9});
    tbl.push_back('{1'b1, 8'hF9,  8'h02, 8'hFD, 8'hFF, 1'b0, 9});
    tbl.push_back('{1'b1, 8'h07,  8'hFE, 8'hFD, 8'h01, 1'b0, 9});
    tbl.push_back('{1'b0, 8'h2A,  8'h00, 8'hFF, 8'h2A, 1'b1, 1});
    tbl.push_back('{1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 1});
    tbl.push_back('{1'b1, 8'hD6,  8'h00, 8'hFF, 8'hD6, 1'b1, 1});
    tbl.push_back('{1'b0, 8'h00,  8'h05, 8'h00, 8'h00, 1'b0, 9});
    tbl.push_back('{1'b0, 8'h05,  8'h09, 8'h00, 8'h05, 1'b0, 9});
    tbl.push_back('{1'b0, 8'hFF,  8'h10, 8'h0F, 8'h0F, 1'b0, 9});
    tbl.push_back('{1'b0, 8'hFF,  8'hFF, 8'h01, 8'h00, 1'b0, 9});
    tbl.push_back('{1'b0, 8'h80,  8'hFF, 8'h00, 8'h80, 1'b0, 9});
    tbl.push_back('{1'b1, 8'h80,  8'h01, 8'h80, 8'h00, 1'b0, 9});
    tbl.push_back('{1'b1, 8'h81,  8'h07, 8'hEE, 8'hFF, 1'b0, 9});
    tbl.push_back('{1'b1, 8'h80,  8'h02, 8'hC0, 8'h00, 1'b0, 9});

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (tbl[i]) begin
      run_op(tbl[i].sgn, tbl[i].a, tbl[i].b, 0, 0, q, r, z, lat, rb, ok);
      chk($sformatf("tbl%0d_ok", i), 32'(ok), 32'd1);
      chk($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].q));
      chk($sformatf("tbl%0d_r", i), 32'(r), 32'(tbl[i].r));
      chk($sformatf("tbl%0d_dbz", i), 32'(z), 32'(tbl[i].z));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d_in_ready_busy", i), 32'(rb), 32'd0);
    end

    // Backpressure: results held, new operands ignored while DONE waits
    @(negedge clk);
    is_signed = 1'b0; dividend = 8'd200; divisor = 8'd9; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk); lat++;
    end
    chk("bp_valid", 32'(out_valid), 32'd1);
    is_signed = 1'b0; dividend = 8'd3; divisor = 8'd1; in_valid = 1'b1;
    rb = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (quotient !== 8'd22 || remainder !== 8'd2 || div_by_zero !== 1'b0 ||
          out_valid !== 1'b1 || in_ready !== 1'b0) rb++;
    end
    chk("bp_stable_cycles_bad", 32'(rb), 32'd0);
    chk("bp_q", 32'(quotient), 32'd22);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_after_out_valid", 32'(out_valid), 32'd0);
    chk("bp_after_in_ready", 32'(in_ready), 32'd1);
    repeat (12) @(negedge clk);
    chk("bp_no_phantom_result", 32'(out_valid), 32'd0);

    // Reset during iteration 4 aborts; next op clean
    @(negedge clk);
    is_signed = 1'b0; dividend = 8'd200; divisor = 8'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_quotient", 32'(quotient), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 8'd255, 8'd16, 0, 0, q, r, z, lat, rb, ok);
    chk("postrst_ok", 32'(ok), 32'd1);
    chk("postrst_q", 32'(q), 32'd15);
    chk("postrst_r", 32'(r), 32'd15);
    chk("postrst_lat", 32'(lat), 32'd9);

    // Random operands with stalls vs model
    errs_rnd = 0;
    for (int n = 0; n < 2500; n++) begin
      logic       s;
      logic [7:0] a, b;
      int         sel;
      s   = 1'($urandom_range(0, 1));
      a   = 8'($urandom);
      b   = 8'($urandom);
      sel = $urandom_range(0, 15);
      if (sel == 0) b = 8'h00;
      else if (sel == 1) begin s = 1'b1; a = 8'h80; b = 8'hFF; end
      else if (sel == 2) b = 8'($urandom_range(1, 3));
      model(s, a, b, eq, er, ez);
      run_op(s, a, b, $urandom_range(0, 1) * $urandom_range(0, 2),
             $urandom_range(0, 1) * $urandom_range(0, 3), sq, sr, sz, lat, rb, ok);
      chk("rnd_ok", 32'(ok), 32'd1);
      chk($sformatf("rnd_q s=%0d a=%0h b=%0h", s, a, b), 32'(sq), 32'(eq));
      chk($sformatf("rnd_r s=%0d a=%0h b=%0h", s, a, b), 32'(sr), 32'(er));
      chk($sformatf("rnd_dbz s=%0d a=%0h b=%0h", s, a, b), 32'(sz), 32'(ez));
      chk("rnd_in_ready_busy", 32'(rb), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
